// File: rtl/case_1_mul_share_arb.sv
// Round-robin arbiter sharing one signed multiplier across NUM_REQ requesters.
// Two-stage pipeline with backpressure; define CASE_1_MUL_ARB_SAT_EN for saturating output.
module case_1_mul_share_arb #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DIN0_WIDTH = 4,
    parameter int unsigned DIN1_WIDTH = 5,
    parameter int unsigned DOUT_WIDTH = 5,
    localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
    input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [ID_W-1:0]                  rsp_id,
    output logic [DOUT_WIDTH-1:0]            rsp_dout,
    output logic                             busy
);

    localparam int unsigned     PROD_W    = DIN0_WIDTH + DIN1_WIDTH;
    localparam logic [ID_W:0]   NUM_REQ_X = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    // Pipeline state
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [ID_W-1:0]       s1_id_q, s1_id_d;
    logic [DIN0_WIDTH-1:0] s1_din0_q, s1_din0_d;
    logic [DIN1_WIDTH-1:0] s1_din1_q, s1_din1_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic [DOUT_WIDTH-1:0] rsp_dout_q, rsp_dout_d;

    logic adv2;
    logic en1;

    logic [DIN0_WIDTH-1:0] din0_arr [NUM_REQ];
    logic [DIN1_WIDTH-1:0] din1_arr [NUM_REQ];

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W:0]   cand;

    logic signed [PROD_W-1:0] op0_ext;
    logic signed [PROD_W-1:0] op1_ext;
    logic signed [PROD_W-1:0] prod;
    logic [DOUT_WIDTH-1:0]    dout_calc;

    assign adv2 = !rsp_valid_q || rsp_ready;
    assign en1  = !s1_valid_q || adv2;

    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            din0_arr[i] = req_din0[i*DIN0_WIDTH +: DIN0_WIDTH];
            din1_arr[i] = req_din1[i*DIN1_WIDTH +: DIN1_WIDTH];
        end
    end

    // First valid requester at or after ptr, wrapping past NUM_REQ-1.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand >= NUM_REQ_X) begin
                cand = cand - NUM_REQ_X;
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (en1 && grant_found && !ap_rst) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Multiply sits in the S1->S2 path; operands are sign-extended to full product width.
    assign op0_ext = PROD_W'($signed(s1_din0_q));
    assign op1_ext = PROD_W'($signed(s1_din1_q));
    assign prod    = op0_ext * op1_ext;

`ifdef CASE_1_MUL_ARB_SAT_EN
    localparam logic signed [PROD_W-1:0] SAT_MAX =
        {{(PROD_W-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN =
        {{(PROD_W-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

    always_comb begin
        if (prod > SAT_MAX) begin
            dout_calc = SAT_MAX[DOUT_WIDTH-1:0];
        end else if (prod < SAT_MIN) begin
            dout_calc = SAT_MIN[DOUT_WIDTH-1:0];
        end else begin
            dout_calc = prod[DOUT_WIDTH-1:0];
        end
    end
`else
    assign dout_calc = prod[DOUT_WIDTH-1:0];

    if (DOUT_WIDTH < PROD_W) begin : g_trunc
        logic unused_prod_hi;
        assign unused_prod_hi = ^prod[PROD_W-1:DOUT_WIDTH];
    end
`endif

    always_comb begin
        ptr_d       = ptr_q;
        s1_valid_d  = s1_valid_q;
        s1_id_d     = s1_id_q;
        s1_din0_d   = s1_din0_q;
        s1_din1_d   = s1_din1_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_dout_d  = rsp_dout_q;

        if (en1) begin
            s1_valid_d = grant_found;
            if (grant_found) begin
                s1_id_d   = grant_idx;
                s1_din0_d = din0_arr[grant_idx];
                s1_din1_d = din1_arr[grant_idx];
                ptr_d     = (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
            end
        end

        // Result data only moves when S1 actually holds something.
        if (adv2) begin
            rsp_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rsp_id_d   = s1_id_q;
                rsp_dout_d = dout_calc;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s1_din0_q   <= '0;
            s1_din1_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_dout_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            s1_din0_q   <= s1_din0_d;
            s1_din1_q   <= s1_din1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_dout_q  <= rsp_dout_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_dout  = rsp_dout_q;
    assign busy      = s1_valid_q || rsp_valid_q;

endmodule

// File: tb/tb_case_1_mul_share_arb.sv
// Self-checking bench for case_1_mul_share_arb: directed vectors, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_case_1_mul_share_arb;

    localparam int NUM_REQ    = 4;
    localparam int DIN0_WIDTH = 4;
    localparam int DIN1_WIDTH = 5;
    localparam int DOUT_WIDTH = 5;
    localparam int ID_W       = 2;

    logic                          ap_clk = 1'b0;
    logic                          ap_rst = 1'b1;
    logic [NUM_REQ-1:0]            req_valid = '0;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0 = '0;
    logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1 = '0;
    logic                          rsp_valid;
    logic                          rsp_ready = 1'b1;
    logic [ID_W-1:0]               rsp_id;
    logic [DOUT_WIDTH-1:0]         rsp_dout;
    logic                          busy;

    case_1_mul_share_arb #(
        .NUM_REQ   (NUM_REQ),
        .DIN0_WIDTH(DIN0_WIDTH),
        .DIN1_WIDTH(DIN1_WIDTH),
        .DOUT_WIDTH(DOUT_WIDTH)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_din0 (req_din0),
        .req_din1 (req_din1),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_dout (rsp_dout),
        .busy     (busy)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int                    id;
        logic [DOUT_WIDTH-1:0] dout;
    } item_t;

    typedef struct {
        int id;
        int a;
        int b;
        int wrap;
        int sat;
    } vec_t;

    int    n_cmp = 0;
    int    n_err = 0;
    int    op0 [NUM_REQ];
    int    op1 [NUM_REQ];
    item_t q[$];
    bit    head_out = 1'b0;
    int    rr_ptr = 0;
    int    last_grant = -1;
    int    dut_acc = 0;
    int    dut_rsp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product: full-precision integer multiply, then wrap or clamp.
    function automatic logic [DOUT_WIDTH-1:0] ref_dout(input int a, input int b);
        int p;
        int lim;
        p   = a * b;
        lim = 1 << (DOUT_WIDTH - 1);
`ifdef CASE_1_MUL_ARB_SAT_EN
        if (p > lim - 1) p = lim - 1;
        else if (p < -lim) p = -lim;
`endif
        return p[DOUT_WIDTH-1:0];
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_din0[i*DIN0_WIDTH +: DIN0_WIDTH] = op0[i][DIN0_WIDTH-1:0];
            req_din1[i*DIN1_WIDTH +: DIN1_WIDTH] = op1[i][DIN1_WIDTH-1:0];
        end
    endtask

    // One clock: check DUT against the model, take the edge, advance the model.
    // The model holds at most two results in order; room exists if fewer than two
    // are held or the oldest one leaves this cycle.
    task automatic cycle();
        int                 g;
        int                 idx;
        int                 pre;
        bit                 can_acc;
        logic [NUM_REQ-1:0] exp_rdy;
        drive_ops();
        #1;
        can_acc = (q.size() < 2) || (rsp_ready === 1'b1);
        g = -1;
        if (!ap_rst && can_acc) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (rr_ptr + k) % NUM_REQ;
                if (g < 0 && req_valid[idx[ID_W-1:0]]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g[ID_W-1:0]] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("rsp_valid", 32'(rsp_valid), 32'(head_out));
        if (head_out) begin
            check("rsp_id", 32'(rsp_id), 32'(q[0].id));
            check("rsp_dout", 32'(rsp_dout), 32'(q[0].dout));
        end
        check("busy", 32'(busy), 32'(q.size() != 0));
        if ((req_valid & req_ready) != '0) dut_acc++;
        if (rsp_valid && rsp_ready) dut_rsp++;
        @(posedge ap_clk);
        last_grant = g;
        if (ap_rst) begin
            q.delete();
            head_out = 1'b0;
            rr_ptr   = 0;
        end else begin
            if (head_out && rsp_ready) void'(q.pop_front());
            pre = q.size();
            if (g >= 0) begin
                q.push_back('{g, ref_dout(op0[g], op1[g])});
                rr_ptr = (g + 1) % NUM_REQ;
            end
            head_out = (pre > 0);
        end
        #1;
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        cycle();
        ap_rst = 1'b0;
    endtask

    initial begin
        vec_t                  vecs [8];
        int                    e;
        int                    id;
        logic [DOUT_WIDTH-1:0] eb;

        vecs = '{
            '{1, -3,   5, -15, -15},
            '{0,  7,  15,   9,  15},
            '{2, -8,  15,   8, -16},
            '{3, -8, -16,   0,  15},
            '{1,  3,  -4, -12, -12},
            '{2, -1,  -1,   1,   1},
            '{0,  0, -16,   0,   0},
            '{3,  2,   7,  14,  14}
        };
        for (int i = 0; i < NUM_REQ; i++) begin
            op0[i] = i;
            op1[i] = i + 1;
        end

        // Reset: req_ready must stay low while ap_rst is high.
        req_valid = '1;
        drive_ops();
        @(posedge ap_clk);
        #1;
        cycle();
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_dout", 32'(rsp_dout), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        ap_rst    = 1'b0;
        req_valid = '0;

        // Single-request vectors, including the overflow corners.
        rsp_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            id = vecs[v].id;
            op0[id] = vecs[v].a;
            op1[id] = vecs[v].b;
            req_valid = '0;
            req_valid[id[ID_W-1:0]] = 1'b1;
            cycle();
            check("vec_grant", 32'(last_grant), 32'(id));
            req_valid = '0;
            cycle();
`ifdef CASE_1_MUL_ARB_SAT_EN
            e = vecs[v].sat;
`else
            e = vecs[v].wrap;
`endif
            eb = e[DOUT_WIDTH-1:0];
            check("vec_rsp_valid", 32'(rsp_valid), 32'd1);
            check("vec_rsp_id", 32'(rsp_id), 32'(id));
            check("vec_rsp_dout", 32'(rsp_dout), 32'(eb));
        end
        cycle();

        // Round-robin with every requester continuously valid.
        do_reset();
        op0 = '{1, -2, 3, -4};
        op1 = '{5, 6, -7, -8};
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("rr_grant", 32'(last_grant), 32'(k % NUM_REQ));
        end
        req_valid = '0;
        for (int k = 0; k < 3; k++) cycle();

        // Backpressure from an empty pipeline: exactly two accepts, then drain.
        rsp_ready = 1'b0;
        req_valid = '1;
        dut_acc   = 0;
        for (int k = 0; k < 5; k++) cycle();
        check("bp_accepts", 32'(dut_acc), 32'd2);
        rsp_ready = 1'b1;
        req_valid = '0;
        dut_rsp   = 0;
        for (int k = 0; k < 4; k++) cycle();
        check("bp_drained", 32'(dut_rsp), 32'd2);
        check("bp_idle", 32'(busy), 32'd0);

        // Reset with both stages full; pointer must return to 0.
        rsp_ready = 1'b0;
        req_valid = 4'b0110;
        for (int k = 0; k < 3; k++) cycle();
        check("pre_rst_busy", 32'(busy), 32'd1);
        do_reset();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rsp_ready = 1'b1;
        cycle();
        check("post_rst_grant", 32'(last_grant), 32'd1);
        req_valid = '0;
        for (int k = 0; k < 3; k++) cycle();

        // Sparse traffic: each lone requester is granted in its first cycle.
        req_valid = 4'b0100;
        cycle();
        check("sparse_grant2", 32'(last_grant), 32'd2);
        req_valid = 4'b0001;
        cycle();
        check("sparse_grant0", 32'(last_grant), 32'd0);
        req_valid = 4'b0011;
        cycle();
        check("sparse_ptr1", 32'(last_grant), 32'd1);
        req_valid = 4'b0001;
        cycle();
        check("sparse_wrap0", 32'(last_grant), 32'd0);
        req_valid = '0;
        for (int k = 0; k < 3; k++) cycle();

        // Randomized traffic; requesters hold operands until accepted.
        for (int c = 0; c < 3000; c++) begin
            ap_rst    = ($urandom_range(0, 299) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    op0[i] = int'($urandom_range(0, 15)) - 8;
                    op1[i] = int'($urandom_range(0, 31)) - 16;
                end
            end
            cycle();
            if (last_grant >= 0) req_valid[last_grant[ID_W-1:0]] = 1'b0;
        end
        ap_rst    = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        check("final_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/case_1_mul_share_arb.md
# case_1_mul_share_arb

Shares one signed multiplier among NUM_REQ requesters for the case_1 kernel datapath. Arbitration is round-robin, and each requester has its own valid/ready handshake. The block registers operands and products in a two-stage pipeline with backpressure, and returns each result tagged with the requester index. It sits between the per-lane schedulers and the single DIN0_WIDTH x DIN1_WIDTH signed multiply resource.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DIN0_WIDTH, 4, signed operand A width
- DIN1_WIDTH, 5, signed operand B width
- DOUT_WIDTH, 5, result width (≤ DIN0_WIDTH+DIN1_WIDTH)
- ID_W, derived, clog2(NUM_REQ), minimum 1
- ap_clk  in  1  clock; all logic on rising edge
- ap_rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester grant/accept; at most one bit high
- req_din0  in  NUM_REQ*DIN0_WIDTH  operand A, requester i at bits [i*DIN0_WIDTH +: DIN0_WIDTH]
- req_din1  in  NUM_REQ*DIN1_WIDTH  operand B, same packing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  ID_W  index of the requester that produced the result
- rsp_dout  out  DOUT_WIDTH  signed product
- busy  out  1  high when either pipeline stage holds data

## Operation
- Stage S1 registers the granted operands and id (s1_valid). Stage S2 registers the product and id (rsp_valid).
- Advance: adv2 = !rsp_valid || rsp_ready. S2 loads from S1 when adv2. rsp_valid next = s1_valid when adv2, otherwise it holds.
- S1 accept enable: en1 = !s1_valid || adv2.
- Arbiter:
  - Combinational round-robin over req_valid, searching from ptr upward with wrap.
  - req_ready[g] = en1 for the first valid index g; all other bits 0.
  - req_ready depends combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Accept occurs when req_valid[g] && req_ready[g]. S1 captures din0, din1 and g. ptr <= (g+1) mod NUM_REQ.
- If en1 and no request: s1_valid <= 0 and ptr is unchanged.
- Requester obligations: operands stay stable while req_valid is high and unaccepted, and req_valid is not dropped before accept.
- Arithmetic:
  - Full product P = $signed(din0) * $signed(din1), width DIN0_WIDTH+DIN1_WIDTH.
  - Default: rsp_dout = P[DOUT_WIDTH-1:0] (two's-complement wrap).
- Result data and id hold stable while rsp_valid && !rsp_ready.
- busy = s1_valid || rsp_valid.

## Timing
- Reset values (cycle after ap_rst high):
  - rsp_valid, s1_valid, busy = 0
  - rsp_dout = 0, rsp_id = 0, ptr = 0
  - req_ready = 0 during the reset cycle
- Latency: accept at edge N gives rsp_valid high after edge N+1, i.e. 2 cycles from request presented to result visible.
- Throughput: 1 result per cycle with rsp_ready held high.
- Stall: with rsp_valid && !rsp_ready, S1 may still accept one more request if it is empty. After that, all req_ready stay 0.
- Simultaneous rsp_ready and new accept with the pipeline full: S2 takes S1 and S1 takes the new request in the same edge, with no bubble.
- Reset mid-operation drops both stages; in-flight requests are lost and no response is issued. Requesters re-present after reset.
- ptr wraps NUM_REQ-1 -> 0.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 accepts.

## Configuration
- CASE_1_MUL_ARB_SAT_EN defined:
  - rsp_dout saturates instead of wrapping.
  - P > 2^(DOUT_WIDTH-1)-1 gives max positive; P < -2^(DOUT_WIDTH-1) gives min negative; in-range P passes unchanged.
  - The saturation compare is in the S1->S2 path; latency is unchanged.
- Undefined: truncation wrap as in Operation, and no saturation logic is present.

## Test plan
- Single request, default widths: req 1 with din0=-3, din1=5, rsp_ready=1 -> two cycles later rsp_valid=1, rsp_id=1, rsp_dout=5'b10001 (-15).
- Overflow: din0=7, din1=15 -> rsp_dout=9 (wrap) / 15 (SAT_EN). din0=-8, din1=15 -> 8 (wrap) / -16 (SAT_EN). din0=-8, din1=-16 -> 0 (wrap) / 15 (SAT_EN).
- Round-robin: all 4 req_valid held high with distinct operands, rsp_ready=1 -> grants 0,1,2,3,0,… one per cycle; rsp_id sequence matches and products are correct.
- Backpressure: rsp_ready=0 for 5 cycles with requests pending -> exactly 2 accepts, then req_ready=0 and rsp_dout/rsp_id stable. On rsp_ready=1, results drain in order with no loss or duplicate.
- Reset mid-stream: assert ap_rst with both stages full -> next cycle rsp_valid=0, busy=0, ptr=0. First post-reset grant goes to the lowest valid index.
- Sparse traffic: only req 2 valid, then only req 0 valid -> each granted in its first eligible cycle; ptr ends at 1.
